// File: rtl/pipelined_parallel_adder.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES slices of SLICE bits, carry registered
// between slices, operands skewed in and sum deskewed out, valid/ready on both sides.
module pipelined_parallel_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int SLICE = WIDTH / STAGES;

   if (WIDTH % STAGES != 0) begin : g_badSlice
      $error("pipelined_parallel_adder: WIDTH must be a multiple of STAGES");
   end

   logic adv;
   logic ovfReg;

   // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   for (genvar gi = 0; gi < STAGES; gi++) begin : stg
      localparam int LO = gi * SLICE;
      localparam int HI = LO + SLICE;

      logic [WIDTH-LO-1:0] opA;
      logic [WIDTH-LO-1:0] opB;
      logic                cIn;
      logic                vldIn;
      logic [SLICE:0]      part;
      logic [HI-1:0]       sumNext;
      logic                vldReg;
      logic                cyReg;
      logic [HI-1:0]       sumReg;

      if (gi == 0) begin : g_src
         assign opA     = a;
         assign opB     = sub ? ~b : b;
         assign cIn     = sub | cin;
         assign vldIn   = in_valid;
         assign sumNext = part[SLICE-1:0];
      end else begin : g_src
         assign opA     = stg[gi-1].g_skew.aSkewReg;
         assign opB     = stg[gi-1].g_skew.bSkewReg;
         assign cIn     = stg[gi-1].cyReg;
         assign vldIn   = stg[gi-1].vldReg;
         assign sumNext = {part[SLICE-1:0], stg[gi-1].sumReg};
      end

      assign part = {1'b0, opA[SLICE-1:0]} + {1'b0, opB[SLICE-1:0]} + (SLICE+1)'(cIn);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vldReg <= 1'b0;
            cyReg  <= 1'b0;
            sumReg <= '0;
         end else if (adv) begin
            vldReg <= vldIn;
            cyReg  <= part[SLICE];
            sumReg <= sumNext;
         end
      end

      // Upper operand slices ride along until their own stage consumes them.
      if (gi < STAGES - 1) begin : g_skew
         logic [WIDTH-HI-1:0] aSkewReg;
         logic [WIDTH-HI-1:0] bSkewReg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               aSkewReg <= '0;
               bSkewReg <= '0;
            end else if (adv) begin
               aSkewReg <= opA[WIDTH-LO-1:SLICE];
               bSkewReg <= opB[WIDTH-LO-1:SLICE];
            end
         end
      end

      // Same-sign operands giving a different-sign result is exactly carry-in(MSB) ^ carry-out(MSB).
      if (gi == STAGES - 1) begin : g_ovf
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovfReg <= 1'b0;
            end else if (adv) begin
               ovfReg <= (opA[SLICE-1] == opB[SLICE-1]) && (part[SLICE-1] != opA[SLICE-1]);
            end
         end
      end
   end

   assign out_valid = stg[STAGES-1].vldReg;
   assign sum       = stg[STAGES-1].sumReg;
   assign cout      = stg[STAGES-1].cyReg;
   assign ovf       = ovfReg;

endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// Bench for pipelined_parallel_adder: directed corner cases, stall/reset handling and
// random traffic against an arithmetic reference, plus 4/1 and 8/8 configurations.
module tb_pipelined_parallel_adder;
   localparam int S = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] sum;
   logic        cout;
   logic        ovf;

   logic       in4Valid = 1'b0, in4Ready, cin4 = 1'b0, sub4 = 1'b0, out4Valid, cout4, ovf4;
   logic [3:0] a4 = '0, b4 = '0, sum4;
   logic       in8Valid = 1'b0, in8Ready, cin8 = 1'b0, sub8 = 1'b0, out8Valid, cout8, ovf8;
   logic [7:0] a8 = '0, b8 = '0, sum8;
   logic       auxReady = 1'b1;

   int errCount = 0;
   int checkCount = 0;
   int outCount = 0;
   int txnCount = 0;
   logic randReady = 1'b0;

   logic [17:0] expQ[$];
   logic [17:0] q4[$];
   logic [17:0] q8[$];
   logic        heldValid = 1'b0;
   logic [17:0] heldVal = '0;

   always #5 clk = ~clk;

   pipelined_parallel_adder #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipelined_parallel_adder #(.WIDTH(4), .STAGES(1)) dut41 (
      .clk(clk), .rst_n(rst_n), .in_valid(in4Valid), .in_ready(in4Ready),
      .a(a4), .b(b4), .cin(cin4), .sub(sub4), .out_valid(out4Valid), .out_ready(auxReady),
      .sum(sum4), .cout(cout4), .ovf(ovf4)
   );

   pipelined_parallel_adder #(.WIDTH(8), .STAGES(8)) dut88 (
      .clk(clk), .rst_n(rst_n), .in_valid(in8Valid), .in_ready(in8Ready),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out8Valid), .out_ready(auxReady),
      .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   // Reference: {cout, ovf, sum} from unsigned and signed integer arithmetic on w-bit operands.
   function automatic logic [17:0] refModel(input int w, input longint ua, input longint ub,
                                            input logic c, input logic s);
      longint lim  = longint'(1) << w;
      longint half = lim >> 1;
      longint sa   = (ua >= half) ? ua - lim : ua;
      longint sb   = (ub >= half) ? ub - lim : ub;
      longint full;
      longint sres;
      logic [17:0] r;
      if (s) begin
         full = ua + (lim - 1 - ub) + 1;
         sres = sa - sb;
      end else begin
         full = ua + ub + longint'(c);
         sres = sa + sb + longint'(c);
      end
      r        = '0;
      r[17]    = (full >= lim);
      r[16]    = (sres >= half) || (sres < -half);
      r[15:0]  = 16'(full % lim);
      return r;
   endfunction

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
      checkCount++;
      if (got !== want) begin
         errCount++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   // Main scoreboard and output-hold monitor.
   always @(negedge clk) begin
      logic [17:0] want;
      if (!rst_n) begin
         expQ.delete();
         q4.delete();
         q8.delete();
         heldValid = 1'b0;
      end else begin
         if (heldValid) begin
            checkVal("hold_valid", 32'(out_valid), 32'd1);
            checkVal("hold_data", 32'({cout, ovf, sum}), 32'(heldVal));
         end
         heldValid = out_valid && !out_ready;
         heldVal   = {cout, ovf, sum};
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkVal("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
               want = expQ.pop_front();
               checkVal("result", 32'({cout, ovf, sum}), 32'(want));
               txnCount++;
               $display("txn %0d w16: sum=%h cout=%b ovf=%b", txnCount, sum, cout, ovf);
            end
            outCount++;
         end
         if (in_valid && in_ready) expQ.push_back(refModel(16, longint'(a), longint'(b), cin, sub));

         if (out4Valid) begin
            if (q4.size() == 0) checkVal("w4_unexpected", 32'(out4Valid), 32'd0);
            else begin
               want = q4.pop_front();
               checkVal("w4_result", 32'({cout4, ovf4, 12'h000, sum4}), 32'(want));
               txnCount++;
               $display("txn %0d w4: sum=%h cout=%b ovf=%b", txnCount, sum4, cout4, ovf4);
            end
         end
         if (in4Valid && in4Ready) q4.push_back(refModel(4, longint'(a4), longint'(b4), cin4, sub4));

         if (out8Valid) begin
            if (q8.size() == 0) checkVal("w8_unexpected", 32'(out8Valid), 32'd0);
            else begin
               want = q8.pop_front();
               checkVal("w8_result", 32'({cout8, ovf8, 8'h00, sum8}), 32'(want));
               txnCount++;
               $display("txn %0d w8: sum=%h cout=%b ovf=%b", txnCount, sum8, cout8, ovf8);
            end
         end
         if (in8Valid && in8Ready) q8.push_back(refModel(8, longint'(a8), longint'(b8), cin8, sub8));
      end
   end

   // Called at posedge+1; returns at posedge+1 after the op has been accepted.
   task automatic sendOp(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
      int guard = 0;
      a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
      do begin
         @(negedge clk);
         guard++;
      end while (!in_ready && guard < 200);
      if (!in_ready) checkVal("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Single op into an empty pipe; checks latency and the spec's literal result.
   task automatic directedOp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                             input logic c, input logic s, input logic [17:0] want);
      int lat = 0;
      out_ready = 1'b1;
      a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
      do begin
         @(posedge clk); #1;
         lat++;
         if (lat == 1) in_valid = 1'b0;
      end while (!out_valid && lat < 20);
      checkVal({tag, "_latency"}, 32'(lat), 32'(S));
      checkVal({tag, "_value"}, 32'({cout, ovf, sum}), 32'(want));
      @(posedge clk); #1;
   endtask

   initial begin
      int base;
      int guard;

      repeat (2) @(posedge clk);
      #1;
      checkVal("reset_out_valid", 32'(out_valid), 32'd0);
      checkVal("reset_sum", 32'(sum), 32'd0);
      checkVal("reset_cout", 32'(cout), 32'd0);
      checkVal("reset_ovf", 32'(ovf), 32'd0);
      checkVal("reset_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      directedOp("wrap_ffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
      directedOp("carry_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});
      directedOp("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
      directedOp("cin_add", 16'h0001, 16'h0001, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0003});
      directedOp("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
      directedOp("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

      // Back-to-back stream with a 3-cycle output stall in the middle.
      base = outCount;
      fork
         begin
            for (int i = 0; i < 8; i++) sendOp(16'(i), 16'(2 * i), 1'b0, 1'b0);
         end
         begin
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               checkVal("stall_in_ready", 32'(in_ready), 32'd0);
               checkVal("stall_out_valid", 32'(out_valid), 32'd1);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      guard = 0;
      while (outCount < base + 8 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkVal("stream_count", 32'(outCount - base), 32'd8);
      checkVal("stream_queue", 32'(expQ.size()), 32'd0);
      @(posedge clk); #1;

      // Asynchronous reset with three ops in flight.
      for (int i = 0; i < 3; i++) sendOp(16'(100 + i), 16'h0001, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      checkVal("pre_reset_valid", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      checkVal("async_out_valid", 32'(out_valid), 32'd0);
      checkVal("async_sum", 32'(sum), 32'd0);
      checkVal("async_in_ready", 32'(in_ready), 32'd1);
      base = outCount;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (8) begin
         @(negedge clk);
         checkVal("post_reset_idle", 32'(out_valid), 32'd0);
      end
      checkVal("post_reset_count", 32'(outCount - base), 32'd0);
      @(posedge clk); #1;
      directedOp("after_reset", 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555});

      // Random traffic with random producer gaps and random consumer back-pressure.
      randReady = 1'b1;
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               while ($urandom_range(3) == 0) begin
                  @(posedge clk); #1;
               end
               sendOp(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
            randReady = 1'b0;
         end
         begin
            while (randReady) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      guard = 0;
      while (expQ.size() != 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkVal("random_drain", 32'(expQ.size()), 32'd0);

      // Degenerate widths: exhaustive 4-bit single stage, random 8-bit one-bit-per-stage.
      @(posedge clk); #1;
      fork
         begin
            for (int i = 0; i < 1024; i++) begin
               a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8); sub4 = 1'(i >> 9); in4Valid = 1'b1;
               @(posedge clk); #1;
            end
            in4Valid = 1'b0;
         end
         begin
            for (int i = 0; i < 3000; i++) begin
               a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
               in8Valid = 1'b1;
               @(posedge clk); #1;
            end
            in8Valid = 1'b0;
         end
      join
      guard = 0;
      while ((q4.size() != 0 || q8.size() != 0) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkVal("w4_drain", 32'(q4.size()), 32'd0);
      checkVal("w8_drain", 32'(q8.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checkCount, errCount);
      $fatal(1, "watchdog");
   end

endmodule
